// File: rtl/window_mac.sv
// Convolution MAC stage: one KH x KW window per handshake times a preloaded signed kernel,
// plus bias, then arithmetic shift, ReLU and unsigned saturation, under a job-count FSM.
module window_mac #(
    parameter int KW     = 3,
    parameter int KH     = 3,
    parameter int IF_BW  = 8,
    parameter int W_BW   = 8,
    parameter int B_BW   = 8,
    parameter int OUT_BW = 8,
    parameter int SHIFT  = 4,
    parameter int CNT_BW = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_run,
    input  logic [CNT_BW-1:0]        i_num,
    input  logic                     i_w_load,
    input  logic [W_BW*KH*KW-1:0]    i_weight,
    input  logic [B_BW-1:0]          i_bias,
    input  logic [IF_BW*KH*KW-1:0]   s_fmap,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [OUT_BW-1:0]        m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     o_idle,
    output logic                     o_done
);

    localparam int NTAP    = KH * KW;
    localparam int PROD_BW = IF_BW + W_BW + 1;
    localparam int ACC_BW  = PROD_BW + $clog2(NTAP) + 1;
    localparam logic signed [ACC_BW-1:0] OUT_MAX = {{(ACC_BW-OUT_BW){1'b0}}, {OUT_BW{1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // Arithmetic shift, then clamp into the unsigned output range.
    function automatic logic [OUT_BW-1:0] requant(input logic signed [ACC_BW-1:0] acc);
        logic signed [ACC_BW-1:0] res;
        res = acc >>> SHIFT;
        if (res[ACC_BW-1])
            return '0;
        else if (res > OUT_MAX)
            return '1;
        else
            return res[OUT_BW-1:0];
    endfunction

    state_t                    state_q, state_d;
    logic [CNT_BW-1:0]         num_q, num_d;
    logic [CNT_BW-1:0]         in_cnt_q, in_cnt_d;
    logic [CNT_BW-1:0]         out_cnt_q, out_cnt_d;
    logic [W_BW*NTAP-1:0]      weight_q, weight_d;
    logic [B_BW-1:0]           bias_q, bias_d;

    logic                      vld_p1_q, vld_p1_d;
    logic signed [PROD_BW-1:0] prod_p1_q [NTAP];
    logic signed [PROD_BW-1:0] prod_d    [NTAP];
    logic                      vld_p2_q, vld_p2_d;
    logic signed [ACC_BW-1:0]  sum_p2_q, sum_d;
    logic                      m_valid_q, m_valid_d;
    logic [OUT_BW-1:0]         m_data_q, m_data_d;

    logic adv;
    logic accept;
    logic out_hs;

    // A stalled output freezes every stage at once.
    assign adv     = !m_valid_q || m_ready;
    assign s_ready = (state_q == RUN) && adv && (in_cnt_q < num_q);
    assign accept  = s_valid && s_ready;
    assign out_hs  = m_valid_q && m_ready;

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign o_idle  = (state_q == IDLE);
    assign o_done  = (state_q == DONE);

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        weight_d  = weight_q;
        bias_d    = bias_q;
        if (accept)
            in_cnt_d = in_cnt_q + 1'b1;
        if (out_hs)
            out_cnt_d = out_cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (i_w_load) begin
                    weight_d = i_weight;
                    bias_d   = i_bias;
                end
                if (i_run) begin
                    if (i_num != '0) begin
                        state_d   = RUN;
                        num_d     = i_num;
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (accept && (in_cnt_d == num_q))
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (out_cnt_d == num_q)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < NTAP; k++) begin
            prod_d[k] = $signed({{(PROD_BW-IF_BW){1'b0}}, s_fmap[k*IF_BW +: IF_BW]})
                      * $signed({{(PROD_BW-W_BW){weight_q[k*W_BW+W_BW-1]}}, weight_q[k*W_BW +: W_BW]});
        end
        sum_d = $signed({{(ACC_BW-B_BW){bias_q[B_BW-1]}}, bias_q});
        for (int k = 0; k < NTAP; k++) begin
            sum_d = sum_d + $signed({{(ACC_BW-PROD_BW){prod_p1_q[k][PROD_BW-1]}}, prod_p1_q[k]});
        end
        vld_p1_d  = adv ? accept   : vld_p1_q;
        vld_p2_d  = adv ? vld_p1_q : vld_p2_q;
        m_valid_d = adv ? vld_p2_q : m_valid_q;
        m_data_d  = (adv && vld_p2_q) ? requant(sum_p2_q) : m_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            num_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            weight_q  <= '0;
            bias_q    <= '0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            weight_q  <= weight_d;
            bias_q    <= bias_d;
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    // S1 products and S2 bias-plus-sum; qualified by the valid bits, so no reset needed.
    always_ff @(posedge clk) begin
        if (adv) begin
            prod_p1_q <= prod_d;
            sum_p2_q  <= sum_d;
        end
    end

endmodule

// File: tb/tb_window_mac.sv
// Bench for window_mac: randomized jobs scored against an integer-arithmetic convolution model.
module tb_window_mac;

    localparam int KW = 3, KH = 3, IF_BW = 8, W_BW = 8, B_BW = 8, OUT_BW = 8, SHIFT = 4, CNT_BW = 16;
    localparam int NT = KW * KH;

    logic                  clk;
    logic                  rst;
    logic                  i_run;
    logic [CNT_BW-1:0]     i_num;
    logic                  i_w_load;
    logic [W_BW*NT-1:0]    i_weight;
    logic [B_BW-1:0]       i_bias;
    logic [IF_BW*NT-1:0]   s_fmap;
    logic                  s_valid;
    logic                  s_ready;
    logic [OUT_BW-1:0]     m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  o_idle;
    logic                  o_done;

    window_mac #(.KW(KW), .KH(KH), .IF_BW(IF_BW), .W_BW(W_BW), .B_BW(B_BW),
                 .OUT_BW(OUT_BW), .SHIFT(SHIFT), .CNT_BW(CNT_BW)) dut (
        .clk(clk), .rst(rst), .i_run(i_run), .i_num(i_num), .i_w_load(i_w_load),
        .i_weight(i_weight), .i_bias(i_bias), .s_fmap(s_fmap), .s_valid(s_valid),
        .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .o_idle(o_idle), .o_done(o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [W_BW*NT-1:0]  cur_w;
    logic [B_BW-1:0]     cur_b;
    logic [IF_BW*NT-1:0] win_src[$];
    int exp_q[$];
    int got_q[$];
    int done_cnt, sent, stall_viol, mvalid_cnt;
    int first_acc_cyc, first_val_cyc, last_out_cyc, done_cyc, idle_after_done, timed_out;
    int rdy_pct, vld_pct;
    bit inj_run, inj_wload;

    // Reference: plain integer convolution, shift, clamp.
    function automatic int model(input logic [IF_BW*NT-1:0] fm);
        longint acc;
        longint res;
        acc = longint'($signed(cur_b));
        for (int k = 0; k < NT; k++)
            acc += longint'(fm[k*IF_BW +: IF_BW]) * longint'($signed(cur_w[k*W_BW +: W_BW]));
        res = acc >>> SHIFT;
        if (res < 0) return 0;
        if (res > 255) return 255;
        return int'(res);
    endfunction

    function automatic logic [71:0] fill(input logic [7:0] v);
        logic [71:0] r;
        for (int k = 0; k < NT; k++) r[k*8 +: 8] = v;
        return r;
    endfunction

    function automatic logic [71:0] rnd_vec();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[71:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_weights(input logic [71:0] w, input logic [7:0] b);
        i_w_load = 1'b1;
        i_weight = w;
        i_bias   = b;
        tick();
        i_w_load = 1'b0;
        i_weight = ~w;
        i_bias   = ~b;
        cur_w    = w;
        cur_b    = b;
    endtask

    // Drives one job cycle by cycle and records what happened; tests judge the record.
    task automatic run_job(input int n);
        bit          prev_stall;
        logic [7:0]  prev_data;
        bit          finished;
        exp_q.delete();
        got_q.delete();
        done_cnt = 0; sent = 0; stall_viol = 0; mvalid_cnt = 0;
        first_acc_cyc = -1; first_val_cyc = -1; last_out_cyc = -1; done_cyc = -1;
        idle_after_done = 0; timed_out = 0;
        prev_stall = 1'b0; prev_data = '0; finished = 1'b0;
        i_num = 16'(n);
        i_run = 1'b1;
        tick();
        i_run = 1'b0;
        i_num = 16'($urandom);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (o_done) begin
                done_cnt++;
                if (done_cnt == 1) done_cyc = cyc;
            end
            if (done_cnt > 0 && cyc == done_cyc + 1) idle_after_done = int'(o_idle);
            if (m_valid) begin
                mvalid_cnt++;
                if (first_val_cyc < 0) first_val_cyc = cyc;
            end
            if (prev_stall && (!m_valid || m_data !== prev_data)) stall_viol++;
            if (done_cnt > 0 && cyc >= done_cyc + 4) begin
                finished = 1'b1;
                break;
            end
            m_ready  = ($urandom_range(99) < rdy_pct);
            s_valid  = (sent < win_src.size()) && ($urandom_range(99) < vld_pct);
            s_fmap   = (sent < win_src.size()) ? win_src[sent] : rnd_vec();
            i_run    = inj_run && (cyc == 2);
            if (inj_run && cyc == 2) i_num = 16'd3;
            i_w_load = inj_wload && (cyc == 2);
            if (inj_wload && cyc == 2) begin
                i_weight = rnd_vec();
                i_bias   = 8'($urandom);
            end
            #1;
            if (s_valid && s_ready) begin
                exp_q.push_back(model(s_fmap));
                if (sent == 0) first_acc_cyc = cyc;
                sent++;
            end
            if (m_valid && m_ready) begin
                got_q.push_back(int'(m_data));
                last_out_cyc = cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            @(posedge clk);
            #1;
        end
        if (!finished) timed_out = 1;
        i_run = 1'b0; i_w_load = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
        vectors++; if (m_data !== 8'd0) begin errors++; $display("FAIL reset_m_data got=%0d exp=0", m_data); end
        vectors++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got=%0b exp=0", s_ready); end
        vectors++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_o_done got=%0b exp=0", o_done); end
        vectors++; if (o_idle !== 1'b1) begin errors++; $display("FAIL reset_o_idle got=%0b exp=1", o_idle); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        load_weights(fill(8'd1), 8'd0);
        win_src.delete(); win_src.push_back(fill(8'd16));
        rdy_pct = 100; vld_pct = 100;
        run_job(1);
        vectors++; if (got_q.size() != 1) begin errors++; $display("FAIL basic_count got=%0d exp=1", got_q.size()); end
        else begin
            vectors++; if (got_q[0] != 9) begin errors++; $display("FAIL basic_data got=%0d exp=9", got_q[0]); end
        end
        vectors++; if (first_val_cyc - first_acc_cyc != 3) begin errors++; $display("FAIL basic_latency got=%0d exp=3", first_val_cyc - first_acc_cyc); end
        vectors++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
        vectors++; if (done_cyc != last_out_cyc + 1) begin errors++; $display("FAIL basic_done_timing got=%0d exp=%0d", done_cyc, last_out_cyc + 1); end
        vectors++; if (idle_after_done != 1) begin errors++; $display("FAIL basic_idle_after got=%0d exp=1", idle_after_done); end
        vectors++; if (timed_out != 0) begin errors++; $display("FAIL basic_timeout got=%0d exp=0", timed_out); end
    endtask

    task automatic test_relu();
        load_weights(fill(8'hFF), 8'd0);
        win_src.delete(); win_src.push_back(fill(8'd100));
        rdy_pct = 100; vld_pct = 100;
        run_job(1);
        vectors++; if (got_q.size() != 1 || got_q[0] != 0) begin errors++; $display("FAIL relu_neg_weights got=%0d exp=0 (n=%0d)", got_q.size() ? got_q[0] : -1, got_q.size()); end
        load_weights(fill(8'd1), 8'h80);
        win_src.delete(); win_src.push_back(fill(8'd0));
        run_job(1);
        vectors++; if (got_q.size() != 1 || got_q[0] != 0) begin errors++; $display("FAIL relu_neg_bias got=%0d exp=0 (n=%0d)", got_q.size() ? got_q[0] : -1, got_q.size()); end
    endtask

    task automatic test_saturation();
        load_weights(fill(8'd127), 8'd127);
        win_src.delete(); win_src.push_back(fill(8'd255));
        rdy_pct = 100; vld_pct = 100;
        run_job(1);
        vectors++; if (got_q.size() != 1 || got_q[0] != 255) begin errors++; $display("FAIL saturate got=%0d exp=255 (n=%0d)", got_q.size() ? got_q[0] : -1, got_q.size()); end
    endtask

    task automatic test_stream_backpressure();
        load_weights(fill(8'd1), 8'd0);
        win_src.delete();
        for (int k = 1; k <= 23; k++) win_src.push_back(fill(8'(k)));
        rdy_pct = 50; vld_pct = 80;
        run_job(20);
        vectors++; if (sent != 20) begin errors++; $display("FAIL stream_accepted got=%0d exp=20", sent); end
        vectors++; if (got_q.size() != 20) begin errors++; $display("FAIL stream_outputs got=%0d exp=20", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 20; i++) begin
            vectors++; if (got_q[i] != ((9 * (i + 1)) >> 4)) begin errors++; $display("FAIL stream_data[%0d] got=%0d exp=%0d", i, got_q[i], (9 * (i + 1)) >> 4); end
        end
        vectors++; if (stall_viol != 0) begin errors++; $display("FAIL stream_stall_stable got=%0d exp=0", stall_viol); end
        vectors++; if (done_cnt != 1) begin errors++; $display("FAIL stream_done_count got=%0d exp=1", done_cnt); end
        vectors++; if (timed_out != 0) begin errors++; $display("FAIL stream_timeout got=%0d exp=0", timed_out); end
    endtask

    task automatic test_random_with_injections();
        load_weights(rnd_vec(), 8'($urandom));
        win_src.delete();
        for (int k = 0; k < 30; k++) win_src.push_back(rnd_vec());
        rdy_pct = 60; vld_pct = 70; inj_run = 1'b1; inj_wload = 1'b1;
        run_job(30);
        inj_run = 1'b0; inj_wload = 1'b0;
        vectors++; if (sent != 30) begin errors++; $display("FAIL rand_accepted got=%0d exp=30", sent); end
        vectors++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_outputs got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++; if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL rand_data[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
        end
        vectors++; if (stall_viol != 0) begin errors++; $display("FAIL rand_stall_stable got=%0d exp=0", stall_viol); end
        vectors++; if (done_cnt != 1) begin errors++; $display("FAIL rand_done_count got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_num_zero();
        win_src.delete(); win_src.push_back(rnd_vec()); win_src.push_back(rnd_vec());
        rdy_pct = 100; vld_pct = 100;
        run_job(0);
        vectors++; if (sent != 0) begin errors++; $display("FAIL zero_accepted got=%0d exp=0", sent); end
        vectors++; if (mvalid_cnt != 0) begin errors++; $display("FAIL zero_m_valid got=%0d exp=0", mvalid_cnt); end
        vectors++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt); end
        vectors++; if (done_cyc < 0 || done_cyc > 1) begin errors++; $display("FAIL zero_done_timing got=%0d exp=0..1", done_cyc); end
    endtask

    task automatic test_back_to_back();
        load_weights(rnd_vec(), 8'($urandom));
        win_src.delete();
        for (int k = 0; k < 10; k++) win_src.push_back(rnd_vec());
        rdy_pct = 100; vld_pct = 100;
        run_job(10);
        vectors++; if (last_out_cyc - first_acc_cyc != 12) begin errors++; $display("FAIL b2b_throughput got=%0d exp=12", last_out_cyc - first_acc_cyc); end
        vectors++; if (got_q.size() != 10) begin errors++; $display("FAIL b2b_outputs got=%0d exp=10", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++; if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL b2b_data[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midjob();
        load_weights(rnd_vec(), 8'($urandom));
        i_num = 16'd5; i_run = 1'b1;
        tick();
        i_run = 1'b0; m_ready = 1'b1; s_valid = 1'b1; s_fmap = rnd_vec();
        #1;
        vectors++; if (s_ready !== 1'b1) begin errors++; $display("FAIL midrst_s_ready got=%0b exp=1", s_ready); end
        tick();
        tick();
        rst = 1'b0; s_valid = 1'b0;
        tick();
        vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_m_valid got=%0b exp=0", m_valid); end
        vectors++; if (o_idle !== 1'b1) begin errors++; $display("FAIL midrst_o_idle got=%0b exp=1", o_idle); end
        vectors++; if (o_done !== 1'b0) begin errors++; $display("FAIL midrst_o_done got=%0b exp=0", o_done); end
        rst = 1'b1;
        tick();
        vectors++; if (o_done !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL midrst_after got=%0b%0b exp=00", o_done, m_valid); end
        cur_w = '0; cur_b = '0;
        win_src.delete(); win_src.push_back(fill(8'd255));
        rdy_pct = 100; vld_pct = 100;
        run_job(1);
        vectors++; if (got_q.size() != 1 || got_q[0] != 0) begin errors++; $display("FAIL midrst_cleared_weights got=%0d exp=0 (n=%0d)", got_q.size() ? got_q[0] : -1, got_q.size()); end
        load_weights(rnd_vec(), 8'($urandom));
        win_src.delete();
        for (int k = 0; k < 3; k++) win_src.push_back(rnd_vec());
        rdy_pct = 70; vld_pct = 70;
        run_job(3);
        vectors++; if (got_q.size() != 3) begin errors++; $display("FAIL midrst_new_job_count got=%0d exp=3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++; if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL midrst_new_job[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        rst = 1'b0; i_run = 1'b0; i_num = '0; i_w_load = 1'b0; i_weight = '0; i_bias = '0;
        s_fmap = '0; s_valid = 1'b0; m_ready = 1'b1;
        inj_run = 1'b0; inj_wload = 1'b0; rdy_pct = 100; vld_pct = 100;
        cur_w = '0; cur_b = '0;
        #1;
        test_reset();
        test_basic();
        test_relu();
        test_saturation();
        test_stream_backpressure();
        test_random_with_injections();
        test_num_zero();
        test_back_to_back();
        test_reset_midjob();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
